if_stage: RTL and testbench

Instruction-fetch stage of the MIPS32 pipeline. It directly feeds the decode stage.
- Owns the program counter.
- Runs a request/acknowledge handshake with instruction memory.
- Registers each fetched instruction and its PC onto the IF/ID boundary.
- Applies branch redirects returned by decode.
- Holds state under pipeline stall.

---
 rtl/if_stage.sv | 73 +++++++
 tb/tb_if_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: MIPS32 fetch stage; PC, memory handshake, skid on stall, branch redirect.
// Define BRANCH_DELAY_SLOT_EN to deliver the branch slot instruction instead of squashing it.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branchEnable_i,
    input  logic [31:0] branchAddr_i,
    output logic [31:0] instAddr_o,
    output logic        instReq_o,
    input  logic        instAck_i,
    input  logic [31:0] instData_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        instValid_o
);
    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;
    state_t      state;
    logic [31:0] pc, skid_inst, skid_pc, redirect_target, d_inst, d_pc, tgt;
    logic        redirect_pending, br, deliver, redir, squash;
    assign instAddr_o = pc;
    assign instReq_o  = state == FETCH;
    always_comb begin
        br      = instValid_o && !stall_i && branchEnable_i;
        deliver = !stall_i && (state == STALL || (state == FETCH && instAck_i));
        d_inst  = state == STALL ? skid_inst : instData_i;
        d_pc    = state == STALL ? skid_pc : pc;
        redir   = redirect_pending || br;
        tgt     = br ? (branchAddr_i & 32'hFFFF_FFFC) : redirect_target;
`ifdef BRANCH_DELAY_SLOT_EN
        squash  = 1'b0;
`else
        squash  = redir;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            redirect_pending <= 1'b0;
            redirect_target  <= 32'h0;
            skid_inst        <= 32'h0;
            skid_pc          <= 32'h0;
            inst_o           <= 32'h0;
            pc_o             <= 32'h0;
            instValid_o      <= 1'b0;
        end else if (deliver) begin
            state            <= FETCH;
            pc               <= redir ? tgt : pc + 32'd4;
            redirect_pending <= 1'b0;
            instValid_o      <= !squash;
            if (!squash) begin
                inst_o <= d_inst;
                pc_o   <= d_pc;
            end
        end else begin
            if (br) begin
                redirect_pending <= 1'b1;
                redirect_target  <= branchAddr_i & 32'hFFFF_FFFC;
            end
            // FETCH without delivery and without stall means no ack: present a bubble
            if (state == FETCH && !stall_i) instValid_o <= 1'b0;
            if (state == FETCH && instAck_i && stall_i) begin
                skid_inst <= instData_i;
                skid_pc   <= pc;
                state     <= STALL;
            end
            if (state == IDLE) state <= FETCH;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage; memory returns data equal to address.
module tb_if_stage;
    logic        clk = 1'b0, rst = 1'b0, stall_i = 1'b0, branchEnable_i = 1'b0;
    logic [31:0] branchAddr_i = 32'h0;
    logic [31:0] instAddr_o, instData_i, inst_o, pc_o;
    logic        instReq_o, instAck_i, instValid_o;
    logic        ack_auto = 1'b1, ack_man = 1'b0;
    int          checks = 0, failures = 0;

    if_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branchEnable_i(branchEnable_i),
        .branchAddr_i(branchAddr_i), .instAddr_o(instAddr_o), .instReq_o(instReq_o),
        .instAck_i(instAck_i), .instData_i(instData_i), .inst_o(inst_o), .pc_o(pc_o),
        .instValid_o(instValid_o)
    );

    always #5 clk = ~clk;
    assign instAck_i  = ack_auto ? instReq_o : ack_man;
    assign instData_i = instAddr_o;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; stall_i = 1'b0; branchEnable_i = 1'b0; branchAddr_i = 32'h0;
        ack_auto = 1'b1; ack_man = 1'b0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        step(); step(); step();
        rst = 1'b0;
        step(); step();
        checks++;
        if (instReq_o !== 1'b0 || instAddr_o !== 32'h0 || inst_o !== 32'h0 || pc_o !== 32'h0 || instValid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state req=%b addr=%h inst=%h pc=%h valid=%b exp all 0", instReq_o, instAddr_o, inst_o, pc_o, instValid_o);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        checks++;
        if (instReq_o !== 1'b0) begin failures++; $display("FAIL zw_idle req=%b exp 0", instReq_o); end
        step();
        checks++;
        if (instReq_o !== 1'b1 || instAddr_o !== 32'h0 || instValid_o !== 1'b0) begin
            failures++; $display("FAIL zw_first_req req=%b addr=%h valid=%b exp 1/0/0", instReq_o, instAddr_o, instValid_o);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instValid_o !== 1'b1 || pc_o !== 32'(4 * i) || inst_o !== 32'(4 * i)) begin
                failures++; $display("FAIL zw_seq%0d valid=%b pc=%h inst=%h exp pc=inst=%h", i, instValid_o, pc_o, inst_o, 4 * i);
            end
            step();
        end
    endtask

    task automatic test_wait2();
        do_reset();
        ack_auto = 1'b0;
        step();
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 3; w++) begin
                ack_man = (w == 2);
                checks++;
                if (instReq_o !== 1'b1 || instAddr_o !== 32'(4 * f) || instValid_o !== (w == 0 && f > 0)) begin
                    failures++;
                    $display("FAIL wait2_f%0d_w%0d req=%b addr=%h valid=%b exp addr=%h", f, w, instReq_o, instAddr_o, instValid_o, 4 * f);
                end
                if (w == 0 && f > 0) begin
                    checks++;
                    if (pc_o !== 32'(4 * (f - 1))) begin failures++; $display("FAIL wait2_pc%0d pc=%h exp %h", f, pc_o, 4 * (f - 1)); end
                end
                step();
            end
        end
        ack_man = 1'b0;
        checks++;
        if (instValid_o !== 1'b1 || pc_o !== 32'h8) begin failures++; $display("FAIL wait2_last valid=%b pc=%h exp 1/8", instValid_o, pc_o); end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        checks++;
        if (instAddr_o !== 32'h8 || pc_o !== 32'h4) begin failures++; $display("FAIL stall_pre addr=%h pc=%h exp 8/4", instAddr_o, pc_o); end
        stall_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall_i = 1'b0;
            checks++;
            if (instReq_o !== 1'b0 || pc_o !== 32'h4 || inst_o !== 32'h4 || instValid_o !== 1'b1 || instAddr_o !== 32'h8) begin
                failures++;
                $display("FAIL stall_hold%0d req=%b pc=%h inst=%h valid=%b addr=%h exp 0/4/4/1/8", i, instReq_o, pc_o, inst_o, instValid_o, instAddr_o);
            end
            step();
        end
        checks++;
        if (pc_o !== 32'h8 || inst_o !== 32'h8 || instValid_o !== 1'b1 || instReq_o !== 1'b1 || instAddr_o !== 32'hC) begin
            failures++;
            $display("FAIL stall_release pc=%h inst=%h valid=%b req=%b addr=%h exp 8/8/1/1/c", pc_o, inst_o, instValid_o, instReq_o, instAddr_o);
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (pc_o !== 32'h10 || instValid_o !== 1'b1 || instAddr_o !== 32'h14) begin
            failures++; $display("FAIL br_pre pc=%h valid=%b addr=%h exp 10/1/14", pc_o, instValid_o, instAddr_o);
        end
        branchEnable_i = 1'b1; branchAddr_i = 32'h40;
        step();
        branchEnable_i = 1'b0;
        checks++;
`ifdef BRANCH_DELAY_SLOT_EN
        if (pc_o !== 32'h14 || instValid_o !== 1'b1 || instAddr_o !== 32'h40) begin
            failures++; $display("FAIL br_slot pc=%h valid=%b addr=%h exp 14/1/40", pc_o, instValid_o, instAddr_o);
        end
`else
        if (pc_o !== 32'h10 || instValid_o !== 1'b0 || instAddr_o !== 32'h40) begin
            failures++; $display("FAIL br_slot pc=%h valid=%b addr=%h exp 10/0/40", pc_o, instValid_o, instAddr_o);
        end
`endif
        step();
        checks++;
        if (pc_o !== 32'h40 || inst_o !== 32'h40 || instValid_o !== 1'b1 || instAddr_o !== 32'h44) begin
            failures++; $display("FAIL br_target pc=%h inst=%h valid=%b addr=%h exp 40/40/1/44", pc_o, inst_o, instValid_o, instAddr_o);
        end
    endtask

    task automatic test_branch_stall();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        branchEnable_i = 1'b1; branchAddr_i = 32'h0000_0043; stall_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall_i = 1'b0;
            checks++;
            if (instReq_o !== 1'b0 || instAddr_o !== 32'h14 || pc_o !== 32'h10 || instValid_o !== 1'b1) begin
                failures++;
                $display("FAIL brst_hold%0d req=%b addr=%h pc=%h valid=%b exp 0/14/10/1", i, instReq_o, instAddr_o, pc_o, instValid_o);
            end
            step();
        end
        branchEnable_i = 1'b0;
        checks++;
`ifdef BRANCH_DELAY_SLOT_EN
        if (instAddr_o !== 32'h40 || pc_o !== 32'h14 || instValid_o !== 1'b1) begin
            failures++; $display("FAIL brst_slot addr=%h pc=%h valid=%b exp 40/14/1", instAddr_o, pc_o, instValid_o);
        end
`else
        if (instAddr_o !== 32'h40 || pc_o !== 32'h10 || instValid_o !== 1'b0) begin
            failures++; $display("FAIL brst_slot addr=%h pc=%h valid=%b exp 40/10/0", instAddr_o, pc_o, instValid_o);
        end
`endif
        step();
        checks++;
        if (pc_o !== 32'h40 || instValid_o !== 1'b1) begin failures++; $display("FAIL brst_target pc=%h valid=%b exp 40/1", pc_o, instValid_o); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        for (int i = 0; i < 9; i++) step();
        ack_auto = 1'b0; ack_man = 1'b0;
        checks++;
        if (instAddr_o !== 32'h20 || instReq_o !== 1'b1) begin failures++; $display("FAIL rmf_pre addr=%h req=%b exp 20/1", instAddr_o, instReq_o); end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (instReq_o !== 1'b0 || instAddr_o !== 32'h0 || inst_o !== 32'h0 || pc_o !== 32'h0 || instValid_o !== 1'b0) begin
            failures++;
            $display("FAIL rmf_reset req=%b addr=%h inst=%h pc=%h valid=%b exp all 0", instReq_o, instAddr_o, inst_o, pc_o, instValid_o);
        end
        rst = 1'b1; ack_man = 1'b1;
        step();
        checks++;
        if (instReq_o !== 1'b1 || instAddr_o !== 32'h0 || instValid_o !== 1'b0) begin
            failures++; $display("FAIL rmf_resume req=%b addr=%h valid=%b exp 1/0/0", instReq_o, instAddr_o, instValid_o);
        end
        step();
        ack_man = 1'b0;
        checks++;
        if (instValid_o !== 1'b1 || pc_o !== 32'h0 || instAddr_o !== 32'h4) begin
            failures++; $display("FAIL rmf_first valid=%b pc=%h addr=%h exp 1/0/4", instValid_o, pc_o, instAddr_o);
        end
    endtask

    initial begin
        #1;
        rst = 1'b1;
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_branch();
        test_branch_stall();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
